// File: rtl/csm_axil_pkg.sv
// Shared types and constants for the CSM AXI4-Lite register bank.
// Response codes, FSM state encodings and address helpers.
package csm_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic int lsb_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/csm_axil_wr_fsm.sv
// AXI4-Lite write path: independent AW/W capture and B response.
// Presents a one-cycle wr_exec with captured index, data and strobe.
module csm_axil_wr_fsm
  import csm_axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  aw_idx,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [1:0]        b_resp,
  output logic              b_valid,
  input  logic              b_ready,
  input  logic              wr_err,
  output logic              wr_exec,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W/8-1:0] wr_strb
);

  wr_state_t state, state_n;
  logic aw_held, aw_held_n;
  logic w_held, w_held_n;
  logic b_valid_n;
  logic [1:0] b_resp_n;

  always_comb begin
    state_n   = state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    b_valid_n = b_valid;
    b_resp_n  = b_resp;
    wr_exec   = 1'b0;
    unique case (state)
      W_IDLE: begin
        if (aw_ready && aw_valid) aw_held_n = 1'b1;
        if (w_ready && w_valid) w_held_n = 1'b1;
        if (aw_held && w_held) begin
          wr_exec   = 1'b1;
          state_n   = W_RESP;
          b_valid_n = 1'b1;
          b_resp_n  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (b_valid && b_ready) begin
          state_n   = W_IDLE;
          b_valid_n = 1'b0;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      wr_idx   <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
    end else begin
      state    <= state_n;
      aw_held  <= aw_held_n;
      w_held   <= w_held_n;
      aw_ready <= (state_n == W_IDLE) && !aw_held_n;
      w_ready  <= (state_n == W_IDLE) && !w_held_n;
      b_valid  <= b_valid_n;
      b_resp   <= b_resp_n;
      if (aw_ready && aw_valid) wr_idx <= aw_idx;
      if (w_ready && w_valid) begin
        wr_data <= w_data;
        wr_strb <= w_strb;
      end
    end
  end

endmodule

// File: rtl/csm_axil_regbank.sv
// Parametrised AXI4-Lite register bank with read-only status registers.
// Owns the register array and the read channel.
module csm_axil_regbank
  import csm_axil_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int LSB    = lsb_bits(DATA_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wr_exec;
  logic              wr_err;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [NUM_REGS-1:0] wr_hit;

  csm_axil_wr_fsm #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_wr (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .aw_idx   (S_AXI_AWADDR[ADDR_W-1:LSB]),
    .aw_valid (S_AXI_AWVALID),
    .aw_ready (S_AXI_AWREADY),
    .w_data   (S_AXI_WDATA),
    .w_strb   (S_AXI_WSTRB),
    .w_valid  (S_AXI_WVALID),
    .w_ready  (S_AXI_WREADY),
    .b_resp   (S_AXI_BRESP),
    .b_valid  (S_AXI_BVALID),
    .b_ready  (S_AXI_BREADY),
    .wr_err   (wr_err),
    .wr_exec  (wr_exec),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb)
  );

  // Only in-range read-write registers can be hit; no hit means SLVERR.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = (wr_idx == IDX_W'(i)) && !RO_MASK[i];
    end
  end

  assign wr_err = ~|wr_hit;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i]) begin
          regs[i] <= hw_in[i*DATA_W +: DATA_W];
        end else if (wr_exec && wr_hit[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
      reg_wr_pulse <= (wr_exec && |wr_strb) ? wr_hit : '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

  rd_state_t rd_state, rd_state_n;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_val;
  logic              rd_err;
  logic              rd_load;

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_val = regs[i];
        rd_err = 1'b0;
      end
    end
  end

  always_comb begin
    rd_state_n = rd_state;
    rd_load    = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        if (S_AXI_ARREADY && S_AXI_ARVALID) rd_state_n = R_DATA;
      end
      R_DATA: begin
        if (!S_AXI_RVALID) rd_load = 1'b1;
        else if (S_AXI_RREADY) rd_state_n = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state      <= R_IDLE;
      rd_idx        <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      rd_state      <= rd_state_n;
      S_AXI_ARREADY <= (rd_state_n == R_IDLE);
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        rd_idx <= S_AXI_ARADDR[ADDR_W-1:LSB];
      end
      if (rd_load) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
        S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0], hw_in};

endmodule

// File: tb/tb_csm_axil_regbank.sv
// Scoreboard bench: three bank configurations driven by one shared bus.
// Expected responses are queued per instance and popped by monitors.
module tb_csm_axil_regbank;
  import csm_axil_pkg::*;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] awaddr = '0;
  logic [11:0] araddr = '0;
  logic [2:0]  prot = '0;
  logic        awvalid = 1'b0;
  logic        wvalid = 1'b0;
  logic        arvalid = 1'b0;
  logic        bready = 1'b1;
  logic        rready = 1'b1;
  logic [63:0] wd = '0;
  logic [7:0]  ws = '0;

  logic awready_a, wready_a, arready_a, bvalid_a, rvalid_a;
  logic [1:0] bresp_a, rresp_a;
  logic [31:0] rdata_a;
  logic [127:0] reg_out_a;
  logic [127:0] hw_in_a = '0;
  logic [3:0] pulse_a;

  logic awready_b, wready_b, arready_b, bvalid_b, rvalid_b;
  logic [1:0] bresp_b, rresp_b;
  logic [31:0] rdata_b;
  logic [95:0] reg_out_b;
  logic [95:0] hw_in_b = {32'hDEAD0001, 64'h0};
  logic [2:0] pulse_b;

  logic awready_c, wready_c, arready_c, bvalid_c, rvalid_c;
  logic [1:0] bresp_c, rresp_c;
  logic [63:0] rdata_c;
  logic [511:0] reg_out_c;
  logic [511:0] hw_in_c = '0;
  logic [7:0] pulse_c;

  csm_axil_regbank #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(4),
                     .RO_MASK(4'b0000)) u_a (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_a),
    .S_AXI_WDATA(wd[31:0]), .S_AXI_WSTRB(ws[3:0]),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a),
    .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
    .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a),
    .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready),
    .reg_out(reg_out_a), .hw_in(hw_in_a), .reg_wr_pulse(pulse_a)
  );

  csm_axil_regbank #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(3),
                     .RO_MASK(3'b100)) u_b (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_b),
    .S_AXI_WDATA(wd[31:0]), .S_AXI_WSTRB(ws[3:0]),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b),
    .S_AXI_BRESP(bresp_b), .S_AXI_BVALID(bvalid_b),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b),
    .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b),
    .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready),
    .reg_out(reg_out_b), .hw_in(hw_in_b), .reg_wr_pulse(pulse_b)
  );

  csm_axil_regbank #(.DATA_W(64), .ADDR_W(12), .NUM_REGS(8),
                     .RO_MASK(8'h00)) u_c (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_c),
    .S_AXI_WDATA(wd), .S_AXI_WSTRB(ws),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_c),
    .S_AXI_BRESP(bresp_c), .S_AXI_BVALID(bvalid_c),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_c),
    .S_AXI_RDATA(rdata_c), .S_AXI_RRESP(rresp_c),
    .S_AXI_RVALID(rvalid_c), .S_AXI_RREADY(rready),
    .reg_out(reg_out_c), .hw_in(hw_in_c), .reg_wr_pulse(pulse_c)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pcnt [4] = '{0, 0, 0, 0};

  logic [1:0] qba[$], qbb[$], qbc[$];
  exp_t qra[$], qrb[$], qrc[$];
  exp_t ea, eb, ec;
  logic ok, ah, wh;

  localparam logic [1:0] OK = RESP_OKAY;
  localparam logic [1:0] SE = RESP_SLVERR;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got response want none", nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d,
                    input logic [7:0] s, input logic [1:0] ra,
                    input logic [1:0] rb, input logic [1:0] rc);
    int n = 0;
    bit ad = 0;
    bit wdn = 0;
    bit ahs, whs;
    qba.push_back(ra);
    qbb.push_back(rb);
    qbc.push_back(rc);
    awaddr = a;
    wd = d;
    ws = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
    while (!(ad && wdn) && n < 50) begin
      ahs = awvalid && awready_a;
      whs = wvalid && wready_a;
      @(posedge clk); #1;
      if (ahs) begin awvalid = 1'b0; ad = 1; end
      if (whs) begin wvalid = 1'b0; wdn = 1; end
      n++;
    end
    if (!(ad && wdn)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wr_timeout: got no handshake want one at %h", a);
      awvalid = 1'b0;
      wvalid = 1'b0;
    end
  endtask

  task automatic rd(input logic [11:0] a,
                    input logic [63:0] da, input logic [1:0] ra,
                    input logic [63:0] db, input logic [1:0] rb,
                    input logic [63:0] dc, input logic [1:0] rc);
    int n = 0;
    bit done = 0;
    bit hs;
    qra.push_back('{da, ra});
    qrb.push_back('{db, rb});
    qrc.push_back('{dc, rc});
    araddr = a;
    arvalid = 1'b1;
    while (!done && n < 50) begin
      hs = arready_a;
      @(posedge clk); #1;
      if (hs) done = 1;
      n++;
    end
    arvalid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL rd_timeout: got no handshake want one at %h", a);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bvalid_a && bready) begin
      if (qba.size() == 0) miss("b_a_extra");
      else chk("bresp_a", 64'(bresp_a), 64'(qba.pop_front()));
    end
    if (rst_n && rvalid_a && rready) begin
      if (qra.size() == 0) miss("r_a_extra");
      else begin
        ea = qra.pop_front();
        chk("rdata_a", 64'(rdata_a), ea.d);
        chk("rresp_a", 64'(rresp_a), 64'(ea.r));
      end
    end
    for (int i = 0; i < 4; i++) if (pulse_a[i]) pcnt[i]++;
  end

  always @(negedge clk) begin
    if (rst_n && bvalid_b && bready) begin
      if (qbb.size() == 0) miss("b_b_extra");
      else chk("bresp_b", 64'(bresp_b), 64'(qbb.pop_front()));
    end
    if (rst_n && rvalid_b && rready) begin
      if (qrb.size() == 0) miss("r_b_extra");
      else begin
        eb = qrb.pop_front();
        chk("rdata_b", 64'(rdata_b), eb.d);
        chk("rresp_b", 64'(rresp_b), 64'(eb.r));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bvalid_c && bready) begin
      if (qbc.size() == 0) miss("b_c_extra");
      else chk("bresp_c", 64'(bresp_c), 64'(qbc.pop_front()));
    end
    if (rst_n && rvalid_c && rready) begin
      if (qrc.size() == 0) miss("r_c_extra");
      else begin
        ec = qrc.pop_front();
        chk("rdata_c", rdata_c, ec.d);
        chk("rresp_c", 64'(rresp_c), 64'(ec.r));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({awready_a, wready_a, arready_a, bvalid_a,
                        rvalid_a, bresp_a, rresp_a,
                        awready_b, wready_b, arready_b, bvalid_b,
                        rvalid_b, bresp_b, rresp_b,
                        awready_c, wready_c, arready_c, bvalid_c,
                        rvalid_c, bresp_c, rresp_c,
                        pulse_a, pulse_b, pulse_c}), 64'h0);
    chk("rst_rdata", rdata_c | 64'(rdata_a) | 64'(rdata_b), 64'h0);
    chk("rst_regout", 64'(|{reg_out_a, reg_out_b, reg_out_c}), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", 64'({awready_a, wready_a, arready_a}), 64'h7);

    wr(12'h0, 64'h1, 8'hFF, OK, OK, OK);
    wr(12'h4, 64'h2, 8'hFF, OK, OK, OK);
    wr(12'h8, 64'h3, 8'hFF, OK, SE, OK);
    wr(12'hC, 64'h4, 8'hFF, OK, SE, OK);
    rd(12'h0, 64'h1, OK, 64'h1, OK, 64'h2, OK);
    rd(12'h4, 64'h2, OK, 64'h2, OK, 64'h2, OK);
    rd(12'h8, 64'h3, OK, 64'hDEAD0001, OK, 64'h4, OK);
    rd(12'hC, 64'h4, OK, 64'h0, SE, 64'h4, OK);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("pulse_once", 64'(pcnt[i]), 64'd1);

    qba.push_back(OK);
    qbb.push_back(OK);
    qbc.push_back(OK);
    wd = 64'hA5A5A5A5;
    ws = 8'h0F;
    wvalid = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      wh = wready_a;
      @(posedge clk); #1;
      if (wh) wvalid = 1'b0;
      if (bvalid_a) ok = 1'b0;
    end
    wvalid = 1'b0;
    chk("w_early_no_b", 64'(ok), 64'd1);
    awaddr = 12'h4;
    awvalid = 1'b1;
    ah = awready_a;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("aw_ready_late", 64'(ah), 64'd1);
    @(posedge clk); #1;
    chk("b_latency", 64'(bvalid_a), 64'd1);
    chk("reg1_a", 64'(reg_out_a[63:32]), 64'hA5A5A5A5);

    wr(12'h8, 64'hFFFFFFFF, 8'h0F, OK, SE, OK);
    wr(12'h8, 64'h12345678, 8'h05, OK, SE, OK);
    wr(12'h8, 64'h0, 8'h00, OK, SE, OK);
    repeat (3) @(posedge clk);
    #1;
    chk("strb_reg2_a", 64'(reg_out_a[95:64]), 64'hFF34FF78);
    chk("strb_reg1_c", reg_out_c[127:64], 64'hFF34FF78);
    chk("strb0_no_pulse", 64'(pcnt[2]), 64'd3);
    rd(12'h8, 64'hFF34FF78, OK, 64'hDEAD0001, OK, 64'hFF34FF78, OK);

    bready = 1'b0;
    wr(12'h0, 64'h55, 8'h0F, OK, OK, OK);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!bvalid_a || bresp_a != OK || awready_a || wready_a) ok = 1'b0;
    end
    chk("b_stall", 64'(ok), 64'd1);
    bready = 1'b1;
    @(posedge clk); #1;

    rready = 1'b0;
    rd(12'h4, 64'hA5A5A5A5, OK, 64'hA5A5A5A5, OK, 64'h55, OK);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rvalid_a || rdata_a != 32'hA5A5A5A5 || arready_a) ok = 1'b0;
    end
    chk("r_stall", 64'(ok), 64'd1);
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    wr(12'h38, 64'h0123456789ABCDEF, 8'hFF, SE, SE, OK);
    rd(12'h38, 64'h0, SE, 64'h0, SE, 64'h0123456789ABCDEF, OK);
    repeat (4) @(posedge clk);
    #1;
    chk("reg7_c", reg_out_c[511:448], 64'h0123456789ABCDEF);
    chk("queues_empty", 64'(qba.size() + qbb.size() + qbc.size() +
                            qra.size() + qrb.size() + qrc.size()), 64'd0);

    awaddr = 12'h0;
    wd = 64'h99;
    ws = 8'hFF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 64'({awready_a, wready_a, arready_a, bvalid_a,
                           rvalid_a, bresp_a, rresp_a, pulse_a}), 64'h0);
    chk("midrst_regout", 64'(|{reg_out_a, reg_out_c}), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_partial_wr", 64'(|{reg_out_a, reg_out_c}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
